// File: rtl/demux_stream_pkg.sv
// ============================================================================
// Module  : demux_stream_pkg
// Brief   : Shared types and constants for the 1:4 stream demultiplexer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package demux_stream_pkg;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  typedef logic [1:0] ch_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module  : demux_slot
// Brief   : One-entry output slot (EMPTY/FULL) with data register; optional
//           delivered-word counter when DEMUX_STREAM_COUNT_EN is defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module demux_slot
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
`ifdef DEMUX_STREAM_COUNT_EN
  ,
  output logic [CNT_W-1:0] count_o
`endif
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             drain;

  assign drain   = (state_q == FULL) && ready_i;
  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;

  // A load wins over a drain, so a same-cycle drain+load stays FULL.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = FULL;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_i) begin
        data_q <= data_i;
      end
    end
  end

`ifdef DEMUX_STREAM_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (drain) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
`endif

endmodule

`default_nettype wire

// File: rtl/demux_1_4_stream.sv
// ============================================================================
// Module  : demux_1_4_stream
// Brief   : Valid/ready 1:4 stream demux with a registered slot per channel.
//           Define DEMUX_STREAM_COUNT_EN to add per-channel drain counters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module demux_1_4_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  ch_sel_t                    in_sel,
  output logic [N_CH-1:0]            out_valid,
  input  logic [N_CH-1:0]            out_ready,
  output logic [N_CH-1:0][WIDTH-1:0] out_data
`ifdef DEMUX_STREAM_COUNT_EN
  ,
  output logic [N_CH-1:0][CNT_W-1:0] out_count
`endif
);

  logic            accept;
  logic [N_CH-1:0] load;

  // Only the selected channel can stall the input.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    assign load[g] = accept && (in_sel == ch_sel_t'(g));

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load[g]),
      .data_i  (in_data),
      .valid_o (out_valid[g]),
      .ready_i (out_ready[g]),
      .data_o  (out_data[g])
`ifdef DEMUX_STREAM_COUNT_EN
      ,
      .count_o (out_count[g])
`endif
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_demux_1_4_stream.sv
// ============================================================================
// Module  : tb_demux_1_4_stream
// Brief   : Self-checking bench for demux_1_4_stream (behavioural model +
//           directed literal checks + random traffic).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_demux_1_4_stream;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [3:0][3:0]  out_data;
`ifdef DEMUX_STREAM_COUNT_EN
  logic [3:0][7:0]  out_count;
`endif

  int checks = 0;
  int errors = 0;

  demux_1_4_stream #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_STREAM_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each channel is a one-word mailbox that is emptied when its
  // consumer is ready and refilled by an accepted input word.
  bit       m_full [4];
  bit [3:0] m_word [4];
  int       m_cnt  [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 1'b0;
        m_word[i] = 4'h0;
        m_cnt[i]  = 0;
      end
    end else begin
      bit acc;
      acc = in_valid && (!m_full[in_sel] || out_ready[in_sel]);
      for (int i = 0; i < 4; i++) begin
        if (m_full[i] && out_ready[i]) begin
          m_full[i] = 1'b0;
          m_cnt[i]  = (m_cnt[i] + 1) % 256;
        end
      end
      if (acc) begin
        m_full[in_sel] = 1'b1;
        m_word[in_sel] = in_data;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_in_ready", {31'd0, in_ready},
        {31'd0, (!m_full[in_sel] || out_ready[in_sel])});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cmp_valid%0d", i), {31'd0, out_valid[i]}, {31'd0, m_full[i]});
      chk($sformatf("cmp_data%0d", i), {28'd0, out_data[i]}, {28'd0, m_word[i]});
`ifdef DEMUX_STREAM_COUNT_EN
      chk($sformatf("cmp_count%0d", i), {24'd0, out_count[i]}, m_cnt[i]);
`endif
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  bit hold;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {28'd0, out_valid}, 32'h0);
    chk("reset_out_data", {16'd0, out_data}, 32'h0);

    // First load into channel 2.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hA; out_ready = 4'h0;
    #1 chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t1_out_valid", {28'd0, out_valid}, 32'b0100);
    chk("t1_out_data2", {28'd0, out_data[2]}, 32'hA);

    // Head-of-line block on channel 2 until its consumer is ready.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 4'h5;
    repeat (3) begin
      #1 chk("t2_stalled", {31'd0, in_ready}, 32'd0);
      cyc();
      chk("t2_hold_data", {28'd0, out_data[2]}, 32'hA);
    end
    out_ready = 4'b0100;
    #1 chk("t2_released", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0; out_ready = 4'h0;
    chk("t2_new_data", {28'd0, out_data[2]}, 32'h5);
    chk("t2_still_valid", {31'd0, out_valid[2]}, 32'd1);

    // Other channel is not stalled by the full channel 2.
    in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h3;
    #1 chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t3_out_valid", {28'd0, out_valid}, 32'b0101);

    // Back-to-back stream with all consumers ready.
    out_ready = 4'hF;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_sel = 2'(k % 4); in_data = 4'(k + 1);
      #1 chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("t4_valid", {31'd0, out_valid[k % 4]}, 32'd1);
      chk("t4_data", {28'd0, out_data[k % 4]}, k + 1);
    end
    in_valid = 1'b0;
    cyc();

    // Random traffic, honouring the hold-while-stalled input contract.
    hold = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 4'($urandom_range(0, 15));
      end
      out_ready = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15) | $urandom_range(0, 15));
      #1 hold = in_valid && !in_ready;
      cyc();
    end

    // Fill all four slots then reset asynchronously mid-cycle.
    in_valid = 1'b0; out_ready = 4'h0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 4'(k + 6);
      cyc();
    end
    in_valid = 1'b0;
    chk("t5_all_full", {28'd0, out_valid}, 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", {28'd0, out_valid}, 32'h0);
    chk("t5_async_data", {16'd0, out_data}, 32'h0);
    chk("t5_async_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    rst = 1'b0;

`ifdef DEMUX_STREAM_COUNT_EN
    out_ready = 4'b0010;
    for (int k = 0; k < 257; k++) begin
      in_valid = 1'b1; in_sel = 2'd1; in_data = 4'($urandom_range(0, 15));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    chk("t6_count_wrap", {out_count}, {8'd0, 8'd0, 8'd1, 8'd0});
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Stream demultiplexer: one valid/ready input stream carrying a 2-bit channel select is routed to one of four valid/ready output channels. Each output channel has a one-entry register slot, so outputs are fully registered and per-channel backpressure is isolated. It is the distribution-side counterpart of the 4:1 combinational select blocks, used wherever one producer feeds four independent consumers.

## Interface
- WIDTH, 4, data width per word
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input word present
- in_ready  output  1  input accepted this cycle when in_valid && in_ready
- in_data  input  WIDTH  input word
- in_sel  input  2  destination channel 0..3, qualified by in_valid
- out_valid  output  4  bit i: channel i slot holds a word
- out_ready  input  4  bit i: consumer i takes word this cycle
- out_data  output  4 x WIDTH (packed [3:0][WIDTH-1:0])  slot contents per channel
- out_count  output  4 x 8  per-channel delivered-word counters (only with DEMUX_STREAM_COUNT_EN)

## Operation
- Per-channel slot FSM, two states: EMPTY, FULL. out_valid[i] = (state[i] == FULL).
- in_ready = (state[in_sel] == EMPTY) || out_ready[in_sel]; combinational, depends only on the selected channel. Unselected channels never stall the input.
- Load: in_valid && in_ready -> slot[in_sel] <= in_data, state -> FULL.
- Drain: out_valid[i] && out_ready[i] -> state[i] -> EMPTY unless a load to i happens the same cycle.
- Simultaneous drain and load on the same channel: old word is consumed, new word loaded, state stays FULL, no bubble.
- Drains on multiple channels happen independently in the same cycle as a load on any channel.
- Head-of-line blocking: if slot[in_sel] is FULL and out_ready[in_sel]=0, in_ready=0; input holds; other channels keep draining.
- Input contract: in_data/in_sel stable while in_valid && !in_ready; violations are not detected.
- out_data[i] changes only on a load to channel i; holds last value while EMPTY.
- Words on one channel are delivered in acceptance order; no ordering across channels.

## Timing
- Latency input accept -> out_valid[i]: 1 cycle.
- Throughput: 1 word/cycle when the destination slot is empty or draining.
- Reset (async assert, any time, including mid-transfer): all states EMPTY, out_valid=4'b0000, out_data all zero, out_count all zero; in-flight words are lost. in_ready after reset = 1 (all slots empty).
- First load possible on the first rising edge after rst deasserts.
- in_ready has a combinational path from in_sel and out_ready; no path from in_valid.

## Configuration
- DEMUX_STREAM_COUNT_EN defined: out_count port present; out_count[i] increments by 1 on each drain of channel i (out_valid[i] && out_ready[i]), 8-bit, wraps 255 -> 0, reset to 0.
- Undefined: no out_count port, no counter logic; all other behaviour identical.

## Structure
- Package demux_stream_pkg: N_CH = 4, CNT_W = 8, typedef logic [1:0] ch_sel_t, typedef enum logic {EMPTY, FULL} slot_state_t.
- Sub-module demux_slot: one slot FSM + data register (+ counter under macro), with load, data, out_valid, out_ready, count; instantiated 4 times by generate.
- Top level holds select decode and in_ready mux.

## Test plan
- Reset then in_valid=1, in_sel=2, in_data=4'hA, all out_ready=0 -> in_ready=1; next cycle out_valid=4'b0100, out_data[2]=4'hA.
- Channel 2 FULL, out_ready[2]=0, send in_sel=2, 4'h5 -> in_ready=0 until out_ready[2]=1; that cycle in_ready=1, next cycle out_data[2]=4'h5, out_valid[2] stays 1.
- Channel 2 FULL and stalled, send in_sel=0, 4'h3 -> in_ready=1, next cycle out_valid=4'b0101.
- All out_ready=1, stream in_sel 0,1,2,3,0 with data 1,2,3,4,5 back-to-back -> each word appears on its channel 1 cycle later, in_ready never drops.
- Assert rst mid-stream with out_valid=4'b1111 -> out_valid=0 and out_data=0 immediately (asynchronous), in_ready=1.
- With DEMUX_STREAM_COUNT_EN: 257 drains on channel 1 -> out_count[1]=1, others 0.
